// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing for the 5-stage RV64 core.
// Keeps a per-register in-flight writer count and raises hazard_nop for
// RAW conflicts that the WB bypass cannot cover. It sequences multi-cycle
// flushes after EXU redirects and freezes the pipe while the LSU is busy.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 2,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              dec_valid,
    input  logic [4:0]        dec_rs1,
    input  logic [4:0]        dec_rs2,
    input  logic              dec_need_rs1,
    input  logic              dec_need_rs2,
    input  logic [4:0]        dec_rd,
    input  logic              dec_wr_en,
    input  logic              exu_redirect,
    input  logic              mem_busy,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    output logic              hazard_nop,
    output logic              flush_nop,
    output logic              pipe_stall,
    output logic              issue_fire,
    output logic              sb_overflow,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    typedef enum logic {IDLE, FLUSH} fstate_t;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [1:0]       FLUSH_LOAD = 2'(FLUSH_CYCLES);

    fstate_t          fstate;
    logic [1:0]       fcnt;
    // Entry 0 is never incremented or decremented, so it stays 0 after reset.
    logic [CNT_W-1:0] sb_cnt [32];
    logic [CNT_W-1:0] cnt_rs1, cnt_rs2;
    logic             fwd1, fwd2, raw1, raw2, raw_any;
    logic             inc, dec, same_reg;
    logic [31:0]      inc_vec, dec_vec;

    assign pipe_stall = mem_busy;
    assign flush_nop  = exu_redirect | (fstate == FLUSH);

    assign cnt_rs1 = sb_cnt[dec_rs1];
    assign cnt_rs2 = sb_cnt[dec_rs2];

    // A WB of the last outstanding writer in this cycle satisfies the read.
    assign fwd1 = wb_en & (wb_rd == dec_rs1) & (cnt_rs1 == CNT_W'(1));
    assign fwd2 = wb_en & (wb_rd == dec_rs2) & (cnt_rs2 == CNT_W'(1));
    assign raw1 = dec_need_rs1 & (dec_rs1 != 5'd0) & (cnt_rs1 != '0) & ~fwd1;
    assign raw2 = dec_need_rs2 & (dec_rs2 != 5'd0) & (cnt_rs2 != '0) & ~fwd2;
    assign raw_any = raw1 | raw2;

    assign hazard_nop = dec_valid & ~flush_nop & ~pipe_stall & raw_any;
    assign issue_fire = dec_valid & ~flush_nop & ~pipe_stall & ~raw_any;

    assign inc      = issue_fire & dec_wr_en & (dec_rd != 5'd0);
    assign dec      = wb_en & (wb_rd != 5'd0);
    assign same_reg = inc & dec & (dec_rd == wb_rd);

    // One-hot increment/decrement selects per architectural register.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc) inc_vec[dec_rd] = 1'b1;
        if (dec) dec_vec[wb_rd]  = 1'b1;
    end

    // Scoreboard counters: saturate at max, clamp at zero, cancel on same reg.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < 32; r++) sb_cnt[r] <= '0;
            sb_overflow <= 1'b0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    if (sb_cnt[r] != CNT_MAX) sb_cnt[r] <= sb_cnt[r] + 1'b1;
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    if (sb_cnt[r] != '0) sb_cnt[r] <= sb_cnt[r] - 1'b1;
                end
            end
            if (inc && !same_reg && (sb_cnt[dec_rd] == CNT_MAX))
                sb_overflow <= 1'b1;
        end
    end

    // Flush sequencer: a redirect (re)loads the count, stalls freeze it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            fstate <= IDLE;
            fcnt   <= 2'd0;
        end else if (exu_redirect) begin
            fstate <= FLUSH;
            fcnt   <= FLUSH_LOAD;
        end else if (fstate == FLUSH && !pipe_stall) begin
            fcnt <= fcnt - 2'd1;
            if (fcnt == 2'd1) fstate <= IDLE;
        end
    end

    // Performance counters, wrapping naturally at PERF_W bits.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard_nop || pipe_stall) stall_cnt <= stall_cnt + 1'b1;
            if (exu_redirect)             flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
